// File: rtl/display_scan_ctrl_if.sv
// Avalon-MM slave bus for the display scan controller.
// Carries the register-access signals between CPU and display block.
interface display_scan_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-segment scanner with blanking and blink.
// CPU sets digits/masks; frames latch to a shadow copy at digit 0.
module display_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 12500000
) (
  input  logic               clk,
  input  logic               reset_n,
  display_scan_ctrl_if.slave bus,
  output logic [7:0]         seg_n,
  output logic [3:0]         an_n
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          phase, phase_n;

  logic [15:0] digits, digits_n;
  logic [3:0]  dp_mask, dp_mask_n;
  logic [3:0]  bl_mask, bl_mask_n;
  logic        enable, enable_n;

  logic [15:0] sh_dig, sh_dig_n;
  logic [3:0]  sh_dp, sh_dp_n;
  logic [3:0]  sh_bl, sh_bl_n;

  logic [7:0] seg_d;
  logic [3:0] an_d;
  logic       wr;
  logic       latch;
  logic       dark;
  logic [3:0] nib;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    unique case (d)
      4'h0: dec7 = 7'h3F;
      4'h1: dec7 = 7'h06;
      4'h2: dec7 = 7'h5B;
      4'h3: dec7 = 7'h4F;
      4'h4: dec7 = 7'h66;
      4'h5: dec7 = 7'h6D;
      4'h6: dec7 = 7'h7D;
      4'h7: dec7 = 7'h07;
      4'h8: dec7 = 7'h7F;
      4'h9: dec7 = 7'h6F;
      4'hA: dec7 = 7'h40;
      default: dec7 = 7'h00;
    endcase
  endfunction

  assign wr = bus.chipselect & ~bus.write_n;

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0: bus.readdata = {16'h0, digits};
      2'd1: bus.readdata = {24'h0, bl_mask, dp_mask};
      2'd2: bus.readdata = {31'h0, enable};
      2'd3: bus.readdata = {29'h0, phase, idx};
    endcase
  end

  // Register file next values; these feed the shadow so a
  // write landing on the latch cycle is captured.
  always_comb begin
    digits_n  = digits;
    dp_mask_n = dp_mask;
    bl_mask_n = bl_mask;
    enable_n  = enable;
    if (wr) begin
      unique case (bus.address)
        2'd0: digits_n = bus.writedata[15:0];
        2'd1: begin
          dp_mask_n = bus.writedata[3:0];
          bl_mask_n = bus.writedata[7:4];
        end
        2'd2: enable_n = bus.writedata[0];
        2'd3: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    if (!enable_n) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = idx + 2'd1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    bcnt_n  = bcnt;
    phase_n = phase;
    if (!enable_n) begin
      bcnt_n  = '0;
      phase_n = 1'b0;
    end else if (enable) begin
      if (bcnt == BLINK_LAST) begin
        bcnt_n  = '0;
        phase_n = ~phase;
      end else begin
        bcnt_n = bcnt + 1'b1;
      end
    end
  end

  always_comb begin
    latch    = (state_n == BLANK) && (idx_n == 2'd0)
            && (state != BLANK);
    sh_dig_n = latch ? digits_n  : sh_dig;
    sh_dp_n  = latch ? dp_mask_n : sh_dp;
    sh_bl_n  = latch ? bl_mask_n : sh_bl;
  end

  // Outputs decoded from next-state so they align with the state reg.
  always_comb begin
    nib   = sh_dig_n[{idx_n, 2'b00} +: 4];
    dark  = (state_n != SHOW) || (phase_n && sh_bl_n[idx_n]);
    seg_d = 8'hFF;
    an_d  = 4'hF;
    if (!dark) begin
      seg_d = ~{sh_dp_n[idx_n], dec7(nib)};
      an_d  = ~(4'b0001 << idx_n);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      bcnt    <= '0;
      phase   <= 1'b0;
      digits  <= '0;
      dp_mask <= '0;
      bl_mask <= '0;
      enable  <= 1'b0;
      sh_dig  <= '0;
      sh_dp   <= '0;
      sh_bl   <= '0;
      seg_n   <= 8'hFF;
      an_n    <= 4'hF;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      bcnt    <= bcnt_n;
      phase   <= phase_n;
      digits  <= digits_n;
      dp_mask <= dp_mask_n;
      bl_mask <= bl_mask_n;
      enable  <= enable_n;
      sh_dig  <= sh_dig_n;
      sh_dp   <= sh_dp_n;
      sh_bl   <= sh_bl_n;
      seg_n   <= seg_d;
      an_n    <= an_d;
    end
  end

endmodule
